// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package mips_fetch_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES   = 4;
    localparam logic [31:0] UNMAPPED_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response plus the fetch-to-decode handshake.
// The fetch unit is the master; memory and decode together form the slave.
interface instruction_fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_word;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    modport master (
        output imem_addr,
        output if_valid,
        output if_instr,
        output if_pc,
        input  imem_word,
        input  id_ready
    );

    modport slave (
        input  imem_addr,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output imem_word,
        output id_ready
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Small FIFO of {pc, instr} pairs between fetch and decode.
// Flush beats push; a push into a full buffer is taken only alongside a pop.
module fetch_buffer
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wr_entry_i,
    output fetch_entry_t rd_entry_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam logic [1:0] DEPTH_CNT = DEPTH[1:0];

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o    = (count_q == 2'd0);
    assign full_o     = (count_q == DEPTH_CNT);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign rd_entry_o = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; flush discards everything without a pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_entry_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory,
// queues {pc, instr} for decode and latches a sticky fault on unmapped or
// misaligned addresses until an aligned redirect recovers it.
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            fetch_en,
    input  logic                            redirect,
    input  logic [31:0]                     redirect_pc,
    output logic                            fetch_fault,
    output logic [31:0]                     fault_pc,
    instruction_fetch_unit_if.master        bus
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic         fault_q;
    logic [31:0]  fault_pc_q;

    fetch_entry_t wr_entry;
    fetch_entry_t rd_entry;
    logic         buf_full;
    logic         buf_empty;
    logic         pop;
    logic         space;
    logic         fire;
    logic         unmapped;
    logic         push;

    assign pop      = !buf_empty && bus.id_ready;
    assign space    = !buf_full || pop;
    assign fire     = (state_q == RUN) && fetch_en && !redirect && space;
    assign unmapped = fire && (bus.imem_word == UNMAPPED_WORD);
    assign push     = fire && !unmapped;
    assign wr_entry = '{pc: pc_q, instr: bus.imem_word};

    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = !buf_empty;
    assign bus.if_instr  = rd_entry.instr;
    assign bus.if_pc     = rd_entry.pc;
    assign fetch_fault   = fault_q;
    assign fault_pc      = fault_pc_q;

    fetch_buffer #(
        .DEPTH      (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .pop_i      (pop),
        .flush_i    (redirect),
        .wr_entry_i (wr_entry),
        .rd_entry_o (rd_entry),
        .full_o     (buf_full),
        .empty_o    (buf_empty)
    );

    // PC and fault FSM: reset, then redirect, then unmapped fetch, then normal advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if (redirect) begin
            pc_q <= redirect_pc;
            if (is_word_aligned(redirect_pc)) begin
                state_q <= RUN;
                fault_q <= 1'b0;
            end else begin
                state_q    <= FAULT;
                fault_q    <= 1'b1;
                fault_pc_q <= redirect_pc;
            end
        end else if (unmapped) begin
            state_q    <= FAULT;
            fault_q    <= 1'b1;
            fault_pc_q <= pc_q;
        end else if (push) begin
            pc_q <= pc_q + 32'(INSTR_BYTES);
        end
    end

endmodule
